// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain programming master: serialises host bytes MSB-first onto
// ccff_head with a per-bit prog_en, and packs bits returning on ccff_tail into readback bytes.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             pReset,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             ccff_head,
    output logic             prog_en,
    input  logic             ccff_tail,
    output logic [7:0]       tail_byte,
    output logic             tail_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CHAIN_LEN);

    state_t           state;
    logic [7:0]       shift_reg;
    logic [6:0]       rb_reg;
    logic [2:0]       bit_idx;

    logic [CNT_W-1:0] next_count;
    logic [7:0]       rb_next;
    logic [7:0]       rb_aligned;

    // bit_idx also equals the number of tail bits already held in rb_reg,
    // so the final partial byte is left-aligned by shifting out the unused slots.
    always_comb begin
        next_count = bit_count + CNT_W'(1);
        rb_next    = {rb_reg, ccff_tail};
        rb_aligned = rb_next << (3'd7 - bit_idx);
    end

    always_ff @(posedge clk or posedge pReset) begin
        if (pReset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            rb_reg     <= '0;
            bit_idx    <= '0;
            byte_ready <= 1'b0;
            ccff_head  <= 1'b0;
            prog_en    <= 1'b0;
            tail_byte  <= '0;
            tail_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_count  <= '0;
        end else begin
            tail_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WAIT_BYTE;
                        bit_count  <= '0;
                        rb_reg     <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (byte_valid) begin
                        state      <= SHIFT;
                        shift_reg  <= {byte_in[6:0], 1'b0};
                        ccff_head  <= byte_in[7];
                        prog_en    <= 1'b1;
                        byte_ready <= 1'b0;
                        bit_idx    <= '0;
                    end
                end
                SHIFT: begin
                    rb_reg    <= rb_next[6:0];
                    bit_count <= next_count;
                    bit_idx   <= bit_idx + 3'd1;
                    if (next_count == LAST_COUNT) begin
                        state      <= DONE;
                        prog_en    <= 1'b0;
                        ccff_head  <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        tail_byte  <= rb_aligned;
                        tail_valid <= 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        state      <= WAIT_BYTE;
                        prog_en    <= 1'b0;
                        ccff_head  <= 1'b0;
                        byte_ready <= 1'b1;
                        tail_byte  <= rb_next;
                        tail_valid <= 1'b1;
                    end else begin
                        ccff_head <= shift_reg[7];
                        shift_reg <= {shift_reg[6:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: three instances (chain lengths 16, 12, 1)
// each looped through a behavioural model of the configuration chain.
module tb_ccff_bitstream_loader;

    logic clk = 1'b0;
    logic pReset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: CHAIN_LEN=16
    logic       a_start, a_valid, a_ready, a_head, a_prog_en, a_tail, a_tv, a_busy, a_done;
    logic [7:0] a_byte_in, a_tail_byte;
    logic [15:0] a_count;
    // Instance B: CHAIN_LEN=12
    logic       b_start, b_valid, b_ready, b_head, b_prog_en, b_tail, b_tv, b_busy, b_done;
    logic [7:0] b_byte_in, b_tail_byte;
    logic [15:0] b_count;
    // Instance C: CHAIN_LEN=1
    logic       c_start, c_valid, c_ready, c_head, c_prog_en, c_tail, c_tv, c_busy, c_done;
    logic [7:0] c_byte_in, c_tail_byte;
    logic [15:0] c_count;

    ccff_bitstream_loader #(.CHAIN_LEN(16), .CNT_W(16)) dut_a (
        .clk(clk), .pReset(pReset), .start(a_start), .byte_in(a_byte_in), .byte_valid(a_valid),
        .byte_ready(a_ready), .ccff_head(a_head), .prog_en(a_prog_en), .ccff_tail(a_tail),
        .tail_byte(a_tail_byte), .tail_valid(a_tv), .busy(a_busy), .done(a_done), .bit_count(a_count));
    ccff_bitstream_loader #(.CHAIN_LEN(12), .CNT_W(16)) dut_b (
        .clk(clk), .pReset(pReset), .start(b_start), .byte_in(b_byte_in), .byte_valid(b_valid),
        .byte_ready(b_ready), .ccff_head(b_head), .prog_en(b_prog_en), .ccff_tail(b_tail),
        .tail_byte(b_tail_byte), .tail_valid(b_tv), .busy(b_busy), .done(b_done), .bit_count(b_count));
    ccff_bitstream_loader #(.CHAIN_LEN(1), .CNT_W(16)) dut_c (
        .clk(clk), .pReset(pReset), .start(c_start), .byte_in(c_byte_in), .byte_valid(c_valid),
        .byte_ready(c_ready), .ccff_head(c_head), .prog_en(c_prog_en), .ccff_tail(c_tail),
        .tail_byte(c_tail_byte), .tail_valid(c_tv), .busy(c_busy), .done(c_done), .bit_count(c_count));

    // Chain models: shift on each prog_en cycle, tail is the MSB
    logic [15:0] chain_a = 16'hBEEF;
    logic [11:0] chain_b = 12'hABC;
    logic        chain_c = 1'b1;
    assign a_tail = chain_a[15];
    assign b_tail = chain_b[11];
    assign c_tail = chain_c;

    always @(posedge clk) begin
        if (a_prog_en) chain_a <= {chain_a[14:0], a_head};
        if (b_prog_en) chain_b <= {chain_b[10:0], b_head};
        if (c_prog_en) chain_c <= c_head;
    end

    // Monitors sample mid-cycle
    logic [31:0] a_hlog = '0, b_hlog = '0;
    int a_pcnt = 0, b_pcnt = 0, c_pcnt = 0;
    logic [7:0] a_tq[$];
    logic [7:0] b_tq[$];

    always @(negedge clk) begin
        if (a_prog_en) begin a_hlog <= {a_hlog[30:0], a_head}; a_pcnt <= a_pcnt + 1; end
        if (b_prog_en) begin b_hlog <= {b_hlog[30:0], b_head}; b_pcnt <= b_pcnt + 1; end
        if (c_prog_en) c_pcnt <= c_pcnt + 1;
        if (a_tv) a_tq.push_back(a_tail_byte);
        if (b_tv) b_tq.push_back(b_tail_byte);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        int n = 0;
        a_byte_in = b;
        a_valid = 1'b1;
        while (!a_ready && n < 50) begin tick(); n++; end
        check("a_ready_wait", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("a_first_prog_en", {31'd0, a_prog_en}, 32'd1);
        check("a_first_head", {31'd0, a_head}, {31'd0, b[7]});
    endtask

    task automatic send_b(input logic [7:0] b);
        int n = 0;
        b_byte_in = b;
        b_valid = 1'b1;
        while (!b_ready && n < 50) begin tick(); n++; end
        check("b_ready_wait", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("b_first_head", {31'd0, b_head}, {31'd0, b[7]});
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        check("a_done_wait", {31'd0, a_done}, 32'd1);
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    int p0, q0, n;

    initial begin
        pReset = 1'b1;
        a_start = 0; a_valid = 0; a_byte_in = '0;
        b_start = 0; b_valid = 0; b_byte_in = '0;
        c_start = 0; c_valid = 0; c_byte_in = '0;
        tick(); tick();

        // Reset state
        check("rst_a_ctrl", {26'd0, a_ready, a_head, a_prog_en, a_tv, a_busy, a_done}, 32'd0);
        check("rst_a_tail_byte", {24'd0, a_tail_byte}, 32'd0);
        check("rst_a_count", {16'd0, a_count}, 32'd0);
        check("rst_b_ctrl", {26'd0, b_ready, b_head, b_prog_en, b_tv, b_busy, b_done}, 32'd0);
        pReset = 1'b0;
        tick();

        // Load 0xA5, 0x3C into chain preloaded with 0xBEEF
        pulse_start_a();
        check("a_start_busy", {31'd0, a_busy}, 32'd1);
        check("a_start_ready", {31'd0, a_ready}, 32'd1);
        p0 = a_pcnt; q0 = a_tq.size();
        send_a(8'hA5);
        repeat (7) tick();
        check("a_bit8_prog_en", {31'd0, a_prog_en}, 32'd1);
        check("a_bit8_head", {31'd0, a_head}, 32'd1);
        check("a_bit8_ready", {31'd0, a_ready}, 32'd0);
        check("a_bit8_count", {16'd0, a_count}, 32'd7);
        tick();
        check("a_k9_ready", {31'd0, a_ready}, 32'd1);
        check("a_k9_prog_en", {31'd0, a_prog_en}, 32'd0);
        check("a_k9_head", {31'd0, a_head}, 32'd0);
        check("a_k9_tail_valid", {31'd0, a_tv}, 32'd1);
        check("a_k9_tail_byte", {24'd0, a_tail_byte}, 32'hBE);
        check("a_k9_count", {16'd0, a_count}, 32'd8);
        send_a(8'h3C);
        wait_done_a();
        check("a_done_count", {16'd0, a_count}, 32'd16);
        check("a_done_busy", {31'd0, a_busy}, 32'd0);
        check("a_done_prog_en", {31'd0, a_prog_en}, 32'd0);
        check("a_done_tv", {31'd0, a_tv}, 32'd1);
        tick();
        check("a_tv_pulse", {31'd0, a_tv}, 32'd0);
        check("a_head_seq", {16'd0, a_hlog[15:0]}, 32'hA53C);
        check("a_prog_cycles", a_pcnt - p0, 32'd16);
        check("a_tail_pulses", a_tq.size() - q0, 32'd2);
        if (a_tq.size() >= q0 + 2) begin
            check("a_tail0", {24'd0, a_tq[q0]}, 32'hBE);
            check("a_tail1", {24'd0, a_tq[q0 + 1]}, 32'hEF);
        end
        check("a_chain", {16'd0, chain_a}, 32'hA53C);
        check("a_count_held", {16'd0, a_count}, 32'd16);

        // start in DONE
        pulse_start_a();
        check("a_redo_count", {16'd0, a_count}, 32'd0);
        check("a_redo_busy", {31'd0, a_busy}, 32'd1);
        check("a_redo_ready", {31'd0, a_ready}, 32'd1);
        check("a_redo_done", {31'd0, a_done}, 32'd0);

        // Five-cycle gap between bytes
        p0 = a_pcnt; q0 = a_tq.size();
        send_a(8'hA5);
        n = 0;
        while (!a_ready && n < 50) begin tick(); n++; end
        check("a_gap_ready_wait", {31'd0, a_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("a_gap_prog_en", {31'd0, a_prog_en}, 32'd0);
            check("a_gap_head", {31'd0, a_head}, 32'd0);
            tick();
        end
        check("a_gap_ready_held", {31'd0, a_ready}, 32'd1);
        send_a(8'h3C);
        wait_done_a();
        tick();
        check("a_gap_chain", {16'd0, chain_a}, 32'hA53C);
        check("a_gap_prog_cycles", a_pcnt - p0, 32'd16);
        check("a_gap_tail_pulses", a_tq.size() - q0, 32'd2);
        if (a_tq.size() >= q0 + 2) begin
            check("a_gap_tail0", {24'd0, a_tq[q0]}, 32'hA5);
            check("a_gap_tail1", {24'd0, a_tq[q0 + 1]}, 32'h3C);
        end

        // start ignored in SHIFT, then reset after the 5th bit
        pulse_start_a();
        send_a(8'hA5);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_ign_count", {16'd0, a_count}, 32'd1);
        check("a_ign_prog_en", {31'd0, a_prog_en}, 32'd1);
        tick();
        check("a_ign_count2", {16'd0, a_count}, 32'd2);
        check("a_ign_busy", {31'd0, a_busy}, 32'd1);
        repeat (3) tick();
        check("a_pre_rst_count", {16'd0, a_count}, 32'd5);
        pReset = 1'b1;
        #1;
        check("a_midrst_ctrl", {26'd0, a_ready, a_head, a_prog_en, a_tv, a_busy, a_done}, 32'd0);
        check("a_midrst_tail_byte", {24'd0, a_tail_byte}, 32'd0);
        check("a_midrst_count", {16'd0, a_count}, 32'd0);
        tick();
        pReset = 1'b0;
        tick();
        check("a_idle_after_rst", {30'd0, a_busy, a_ready}, 32'd0);
        // Chain now holds A53C shifted by the five aborted bits 10100
        check("a_chain_partial", {16'd0, chain_a}, 32'hA794);
        p0 = a_pcnt; q0 = a_tq.size();
        pulse_start_a();
        send_a(8'h12);
        send_a(8'h34);
        wait_done_a();
        tick();
        check("a_reload_chain", {16'd0, chain_a}, 32'h1234);
        check("a_reload_prog_cycles", a_pcnt - p0, 32'd16);
        if (a_tq.size() >= q0 + 2) begin
            check("a_reload_tail0", {24'd0, a_tq[q0]}, 32'hA7);
            check("a_reload_tail1", {24'd0, a_tq[q0 + 1]}, 32'h94);
        end else begin
            check("a_reload_tail_pulses", a_tq.size() - q0, 32'd2);
        end

        // CHAIN_LEN=12: 0xFF, 0x80 into chain preloaded with 0xABC
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        send_b(8'hFF);
        send_b(8'h80);
        repeat (3) tick();
        check("b_bit12_prog_en", {31'd0, b_prog_en}, 32'd1);
        check("b_bit12_head", {31'd0, b_head}, 32'd0);
        check("b_bit12_done", {31'd0, b_done}, 32'd0);
        tick();
        check("b_done", {31'd0, b_done}, 32'd1);
        check("b_done_prog_en", {31'd0, b_prog_en}, 32'd0);
        check("b_done_count", {16'd0, b_count}, 32'd12);
        check("b_done_tv", {31'd0, b_tv}, 32'd1);
        check("b_partial_tail", {24'd0, b_tail_byte}, 32'hC0);
        check("b_done_ready", {31'd0, b_ready}, 32'd0);
        tick();
        check("b_prog_cycles", b_pcnt, 32'd12);
        check("b_head_seq", {20'd0, b_hlog[11:0]}, 32'hFF8);
        check("b_chain", {20'd0, chain_b}, 32'hFF8);
        check("b_tail_pulses", b_tq.size(), 32'd2);
        if (b_tq.size() >= 1) check("b_tail0", {24'd0, b_tq[0]}, 32'hAB);

        // CHAIN_LEN=1: single byte 0x80, tail returns 1
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        c_byte_in = 8'h80;
        c_valid = 1'b1;
        n = 0;
        while (!c_ready && n < 50) begin tick(); n++; end
        check("c_ready_wait", {31'd0, c_ready}, 32'd1);
        tick();
        c_valid = 1'b0;
        check("c_prog_en", {31'd0, c_prog_en}, 32'd1);
        check("c_head", {31'd0, c_head}, 32'd1);
        tick();
        check("c_done", {31'd0, c_done}, 32'd1);
        check("c_done_prog_en", {31'd0, c_prog_en}, 32'd0);
        check("c_tv", {31'd0, c_tv}, 32'd1);
        check("c_tail_byte", {24'd0, c_tail_byte}, 32'h80);
        check("c_count", {16'd0, c_count}, 32'd1);
        check("c_busy", {31'd0, c_busy}, 32'd0);
        tick();
        check("c_tv_pulse", {31'd0, c_tv}, 32'd0);
        check("c_prog_cycles", c_pcnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
